icache_sa: RTL

- Parametrised set-associative instruction cache between the IF stage and the memory controller.
- Each line holds one instruction word.
- Lookup is combinational. Misses are serviced by a refill FSM that issues a single-word request to the memory controller.
- The fetched word is forwarded in the refill-complete cycle (bypass). flush_i invalidates the whole array, for fence.i.

---
 rtl/icache_sa_pkg.sv | 16 +
 rtl/icache_way.sv | 58 +++++
 rtl/icache_sa.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/icache_sa_pkg.sv
// Shared parameters and FSM encoding for the set-associative instruction cache.
// Bus widths mirror the core's instruction address and data buses.
package icache_sa_pkg;

  localparam int unsigned ICacheSetBits = 6;
  localparam int unsigned ICacheWays    = 2;
  localparam int unsigned InstAddrBus   = 32;
  localparam int unsigned InstBus       = 32;

  typedef enum logic [1:0] {
    ICacheIdle   = 2'd0,
    ICacheRefill = 2'd1,
    ICacheDrain  = 2'd2
  } icache_state_e;

endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: valid/tag/data arrays with a combinational
// lookup port, a write port for refills and a whole-array invalidate.
module icache_way #(
  parameter int unsigned SET_BITS   = 6,
  parameter int unsigned TAG_WIDTH  = 24,
  parameter int unsigned INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush_i,
  input  logic [SET_BITS-1:0]   lk_idx_i,
  input  logic [TAG_WIDTH-1:0]  lk_tag_i,
  output logic                  match_o,
  output logic [INST_WIDTH-1:0] data_o,
  input  logic [SET_BITS-1:0]   wr_idx_i,
  output logic                  wr_valid_o,
  input  logic                  we_i,
  input  logic [TAG_WIDTH-1:0]  wr_tag_i,
  input  logic [INST_WIDTH-1:0] wr_data_i
);

  localparam int unsigned Sets = 1 << SET_BITS;

  logic [Sets-1:0]       valid_q, valid_d;
  logic [TAG_WIDTH-1:0]  tag_q  [Sets];
  logic [INST_WIDTH-1:0] data_q [Sets];

  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = '0;
    end else if (we_i) begin
      valid_d[wr_idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (rdy) begin
      valid_q <= valid_d;
    end
  end

  // Tag and data are left unreset; valid alone qualifies a line.
  always_ff @(posedge clk) begin
    if (!rst && rdy && we_i && !flush_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign match_o    = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i);
  assign data_o     = data_q[lk_idx_i];
  assign wr_valid_o = valid_q[wr_idx_i];

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache: combinational lookup, single-word refill FSM
// with same-cycle bypass, LRU replacement and fence.i flush.
module icache_sa
  import icache_sa_pkg::*;
#(
  parameter int unsigned SET_BITS   = ICacheSetBits,
  parameter int unsigned WAYS       = ICacheWays,
  parameter int unsigned ADDR_WIDTH = InstAddrBus,
  parameter int unsigned INST_WIDTH = InstBus
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush_i,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] req_pc_i,
  output logic                  hit_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic                  busy_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_done_i,
  input  logic [INST_WIDTH-1:0] mem_inst_i
);

  localparam int unsigned Sets     = 1 << SET_BITS;
  localparam int unsigned WordW    = ADDR_WIDTH - 2;
  localparam int unsigned TagWidth = ADDR_WIDTH - SET_BITS - 2;

  icache_state_e         state_q, state_d;
  logic [WordW-1:0]      mem_word_q, mem_word_d;
  logic [Sets-1:0]       lru_q, lru_d;

  logic [WordW-1:0]      req_word;
  logic [SET_BITS-1:0]   lk_idx, wr_idx;
  logic [TagWidth-1:0]   lk_tag, wr_tag;
  logic [WAYS-1:0]       way_match, way_valid, way_we;
  logic [INST_WIDTH-1:0] way_data [WAYS];

  logic                  any_hit, hit_way, victim, fill, done;
  logic [INST_WIDTH-1:0] hit_data;
  logic                  unused_pc;

  assign req_word  = req_pc_i[ADDR_WIDTH-1:2];
  assign lk_idx    = req_pc_i[SET_BITS+1:2];
  assign lk_tag    = req_pc_i[ADDR_WIDTH-1:SET_BITS+2];
  assign wr_idx    = mem_word_q[SET_BITS-1:0];
  assign wr_tag    = mem_word_q[WordW-1:SET_BITS];
  assign unused_pc = ^req_pc_i[1:0];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_we[w] = fill && (victim == 1'(w));

    icache_way #(
      .SET_BITS  (SET_BITS),
      .TAG_WIDTH (TagWidth),
      .INST_WIDTH(INST_WIDTH)
    ) u_way (
      .clk       (clk),
      .rst       (rst),
      .rdy       (rdy),
      .flush_i   (flush_i),
      .lk_idx_i  (lk_idx),
      .lk_tag_i  (lk_tag),
      .match_o   (way_match[w]),
      .data_o    (way_data[w]),
      .wr_idx_i  (wr_idx),
      .wr_valid_o(way_valid[w]),
      .we_i      (way_we[w]),
      .wr_tag_i  (wr_tag),
      .wr_data_i (mem_inst_i)
    );
  end

  always_comb begin
    any_hit  = 1'b0;
    hit_way  = 1'b0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_match[w] && !any_hit) begin
        any_hit  = 1'b1;
        hit_way  = 1'(w);
        hit_data = way_data[w];
      end
    end
  end

  // Fill an empty way first (way0 preferred); only evict when the set is full.
  always_comb begin
    if (WAYS == 1 || !way_valid[0]) begin
      victim = 1'b0;
    end else if (!way_valid[WAYS-1]) begin
      victim = 1'b1;
    end else begin
      victim = lru_q[wr_idx];
    end
  end

  always_comb begin
    done       = rdy && mem_done_i;
    state_d    = state_q;
    mem_word_d = mem_word_q;
    lru_d      = lru_q;
    fill       = 1'b0;
    hit_o      = 1'b0;
    inst_o     = '0;

    unique case (state_q)
      ICacheIdle: begin
        if (req_i && !flush_i) begin
          if (any_hit) begin
            hit_o  = 1'b1;
            inst_o = hit_data;
            if (WAYS == 2) lru_d[lk_idx] = ~hit_way;
          end else begin
            state_d    = ICacheRefill;
            mem_word_d = req_word;
          end
        end
      end
      ICacheRefill: begin
        if (done) begin
          state_d = ICacheIdle;
          if (!flush_i) begin
            fill = 1'b1;
            if (WAYS == 2) lru_d[wr_idx] = ~victim;
            if (req_i && req_word == mem_word_q) begin
              hit_o  = 1'b1;
              inst_o = mem_inst_i;
            end
          end
        end else if (flush_i) begin
          // The outstanding memory request cannot be cancelled; wait it out.
          state_d = ICacheDrain;
        end
      end
      ICacheDrain: begin
        if (done) state_d = ICacheIdle;
      end
      default: state_d = ICacheIdle;
    endcase

    if (flush_i) lru_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ICacheIdle;
      mem_word_q <= '0;
      lru_q      <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      mem_word_q <= mem_word_d;
      lru_q      <= lru_d;
    end
  end

  assign mem_req_o  = (state_q != ICacheIdle);
  assign busy_o     = (state_q != ICacheIdle);
  assign mem_addr_o = {mem_word_q, 2'b00};

endmodule
